progress_ctrl: RTL and testbench

- Sequences the loading progress bar overlay.
- Arbitrates between two progress sources: ioctl ROM/disk download and tape playback.
- Converts the selected source's position/size into a 7-bit fraction (0-127) with a serial divider.
- Drives the overlay's enable and progress inputs; holds a full bar for a fixed time after the source finishes, then hides it.

---
 rtl/progress_pkg.sv | 12 +
 rtl/progress_div.sv | 53 +++++
 rtl/progress_ctrl.sv | 130 +++++++++++++
 tb/tb_progress_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/progress_pkg.sv
// rtl/progress_pkg.sv - shared state encoding and constants for the progress bar controller
package progress_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_DIVIDE = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam logic [6:0] PROG_MAX  = 7'd127;
  localparam logic [2:0] DIV_STEPS = 3'd7;

endpackage

// File: rtl/progress_div.sv
// rtl/progress_div.sv - serial 7-step restoring divider producing floor(num*128/den) for num < den
module progress_div #(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] num,
  input  logic [AW-1:0] den,
  output logic          done,
  output logic [6:0]    q
);
  import progress_pkg::*;

  logic [AW:0]   rem;
  logic [AW-1:0] den_r;
  logic [6:0]    q_r;
  logic [2:0]    step;
  logic          running;
  logic [AW:0]   shifted;
  logic          take;

  // q and done expose the current step's result so the caller can latch it on the final step
  always_comb begin
    shifted = rem << 1;
    take    = shifted >= {1'b0, den_r};
    q       = {q_r[5:0], take};
    done    = running && (step == DIV_STEPS - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      rem     <= '0;
      den_r   <= '0;
      q_r     <= '0;
      step    <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= {1'b0, num};
      den_r   <= den;
      q_r     <= '0;
      step    <= '0;
      running <= 1'b1;
    end else if (running) begin
      rem  <= take ? (shifted - {1'b0, den_r}) : shifted;
      q_r  <= q;
      step <= step + 3'd1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/progress_ctrl.sv
// rtl/progress_ctrl.sv - loading progress bar sequencer: source arbitration, fraction refresh, post-completion hold
module progress_ctrl #(
  parameter int          AW          = 25,
  parameter logic [23:0] HOLD_CYCLES = 24'd4000000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dl_active,
  input  logic [AW-1:0] dl_addr,
  input  logic [AW-1:0] dl_size,
  input  logic          tape_active,
  input  logic [AW-1:0] tape_pos,
  input  logic [AW-1:0] tape_size,
  input  logic          osd_visible,
  output logic          enable,
  output logic [6:0]    progress,
  output logic          src,
  output logic          busy
);
  import progress_pkg::*;

  logic [1:0]    state, state_n;
  logic          src_n;
  logic [6:0]    prog_n;
  logic [23:0]   hold_cnt, hold_n;
  logic          dl_q, tape_q, dl_rise, tape_rise;
  logic          sel_active;
  logic [AW-1:0] num, den;
  logic          div_start, div_abort, div_done;
  logic [6:0]    div_q;

  assign busy = (state != ST_IDLE);

  always_comb begin
    sel_active = src ? tape_active : dl_active;
    num        = src ? tape_pos : dl_addr;
    den        = src ? tape_size : dl_size;
    dl_rise    = dl_active && !dl_q;
    tape_rise  = tape_active && !tape_q;
    div_start  = (state == ST_SAMPLE) && sel_active && (den != '0) && (num < den);
    div_abort  = (state == ST_DIVIDE) && !sel_active;
  end

  progress_div #(.AW(AW)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (div_start),
    .abort (div_abort),
    .num   (num),
    .den   (den),
    .done  (div_done),
    .q     (div_q)
  );

  always_comb begin
    state_n = state;
    src_n   = src;
    prog_n  = progress;
    hold_n  = hold_cnt;
    // A dropped source beats a completing divide
    if ((state == ST_SAMPLE || state == ST_DIVIDE) && !sel_active) begin
      state_n = ST_HOLD;
      prog_n  = PROG_MAX;
      hold_n  = HOLD_CYCLES - 24'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          prog_n = '0;
          if (dl_active) begin
            state_n = ST_SAMPLE;
            src_n   = 1'b0;
          end else if (tape_active) begin
            state_n = ST_SAMPLE;
            src_n   = 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (den == '0)      prog_n = '0;
          else if (num >= den) prog_n = PROG_MAX;
          else                 state_n = ST_DIVIDE;
        end
        ST_DIVIDE: begin
          if (div_done) begin
            prog_n  = div_q;
            state_n = ST_SAMPLE;
          end
        end
        ST_HOLD: begin
          // Only a fresh activation cuts the hold short; a source already waiting gets picked up from IDLE
          if (dl_rise) begin
            state_n = ST_SAMPLE;
            src_n   = 1'b0;
            prog_n  = '0;
          end else if (tape_rise) begin
            state_n = ST_SAMPLE;
            src_n   = 1'b1;
            prog_n  = '0;
          end else if (hold_cnt == '0) begin
            state_n = ST_IDLE;
            prog_n  = '0;
          end else begin
            hold_n = hold_cnt - 24'd1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      src      <= 1'b0;
      progress <= '0;
      enable   <= 1'b0;
      hold_cnt <= '0;
      dl_q     <= 1'b0;
      tape_q   <= 1'b0;
    end else begin
      state    <= state_n;
      src      <= src_n;
      progress <= prog_n;
      enable   <= (state_n != ST_IDLE) && !osd_visible;
      hold_cnt <= hold_n;
      dl_q     <= dl_active;
      tape_q   <= tape_active;
    end
  end

endmodule

// File: tb/tb_progress_ctrl.sv
// tb/tb_progress_ctrl.sv - self-checking bench for progress_ctrl
module tb_progress_ctrl;

  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          dl_active, tape_active, osd_visible;
  logic [AW-1:0] dl_addr, dl_size, tape_pos, tape_size;
  logic          enable, src, busy;
  logic [6:0]    progress;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  progress_ctrl #(.AW(AW), .HOLD_CYCLES(24'd16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dl_active   (dl_active),
    .dl_addr     (dl_addr),
    .dl_size     (dl_size),
    .tape_active (tape_active),
    .tape_pos    (tape_pos),
    .tape_size   (tape_size),
    .osd_visible (osd_visible),
    .enable      (enable),
    .progress    (progress),
    .src         (src),
    .busy        (busy)
  );

  typedef struct packed {
    logic [AW-1:0] num;
    logic [AW-1:0] den;
    logic [6:0]    exp;
  } vec_t;

  vec_t          vecs[$];
  logic [AW-1:0] rn, rd;
  logic          rosd;

  function automatic logic [6:0] ref_prog(input logic [AW-1:0] num, input logic [AW-1:0] den);
    longint n, d;
    n = longint'(num);
    d = longint'(den);
    if (d == 0) return 7'd0;
    if (n >= d) return 7'd127;
    return 7'((n * 128) / d);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic go_idle();
    dl_active   = 1'b0;
    tape_active = 1'b0;
    osd_visible = 1'b0;
    for (int i = 0; i < 40 && busy; i++) tick(1);
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{25'd0,        25'd1000,      7'd0});
    vecs.push_back('{25'd250,      25'd1000,      7'd32});
    vecs.push_back('{25'd999,      25'd1000,      7'd127});
    vecs.push_back('{25'd1000,     25'd1000,      7'd127});
    vecs.push_back('{25'd500,      25'd1000,      7'd64});
    vecs.push_back('{25'd2000,     25'd1000,      7'd127});
    vecs.push_back('{25'd5,        25'd0,         7'd0});
    vecs.push_back('{25'd3,        25'd4,         7'd96});
    vecs.push_back('{25'd1,        25'd3,         7'd42});
    vecs.push_back('{25'd1,        25'd128,       7'd1});
    vecs.push_back('{25'd127,      25'd128,       7'd127});
    vecs.push_back('{25'd1,        25'd129,       7'd0});
    vecs.push_back('{25'h1FFFFFE,  25'h1FFFFFF,   7'd127});
    vecs.push_back('{25'd1,        25'h1FFFFFF,   7'd0});
    vecs.push_back('{25'h0FFFFFF,  25'h1FFFFFF,   7'd63});

    reset = 1'b1;
    dl_active = 1'b0; tape_active = 1'b0; osd_visible = 1'b0;
    dl_addr = '0; dl_size = '0; tape_pos = '0; tape_size = '0;
    tick(3);
    chk("reset_enable", enable, 0);
    chk("reset_progress", progress, 0);
    chk("reset_src", src, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b0;
    tick(1);

    // First result lands on the 9th edge: IDLE, SAMPLE, then 7 divide steps
    dl_addr = 25'd500; dl_size = 25'd1000; dl_active = 1'b1;
    tick(8);
    chk("first_pre_progress", progress, 0);
    chk("first_busy", busy, 1);
    tick(1);
    chk("first_progress", progress, 64);
    chk("first_enable", enable, 1);
    chk("first_src", src, 0);

    foreach (vecs[i]) begin
      dl_addr = vecs[i].num;
      dl_size = vecs[i].den;
      tick(16);
      chk($sformatf("vec%0d_progress", i), progress, vecs[i].exp);
      chk($sformatf("vec%0d_enable", i), enable, 1);
    end

    // Drop during DIVIDE, then a 16-cycle hold
    go_idle();
    dl_addr = 25'd500; dl_size = 25'd1000; dl_active = 1'b1;
    tick(4);
    dl_active = 1'b0;
    tick(1);
    chk("drop_progress", progress, 127);
    chk("drop_busy", busy, 1);
    tick(15);
    chk("hold_end_enable", enable, 1);
    chk("hold_end_progress", progress, 127);
    tick(1);
    chk("post_hold_enable", enable, 0);
    chk("post_hold_progress", progress, 0);
    chk("post_hold_busy", busy, 0);

    // Simultaneous request: download wins, tape waits for the full hold
    go_idle();
    dl_addr = 25'd500; dl_size = 25'd1000;
    tape_pos = 25'd250; tape_size = 25'd1000;
    dl_active = 1'b1; tape_active = 1'b1;
    tick(1);
    chk("both_src", src, 0);
    tick(16);
    chk("both_progress", progress, 64);
    dl_active = 1'b0;
    tick(1);
    chk("both_drop_progress", progress, 127);
    tick(15);
    chk("both_hold_src", src, 0);
    chk("both_hold_busy", busy, 1);
    tick(1);
    chk("both_idle_busy", busy, 0);
    chk("both_idle_progress", progress, 0);
    tick(1);
    chk("tape_src", src, 1);
    chk("tape_start_progress", progress, 0);
    tick(16);
    chk("tape_progress", progress, 32);

    // Zero size, OSD masking, and drop out of a zero-size sample loop
    go_idle();
    dl_addr = 25'd5; dl_size = 25'd0; dl_active = 1'b1;
    tick(20);
    chk("zero_progress", progress, 0);
    chk("zero_busy", busy, 1);
    osd_visible = 1'b1; dl_addr = 25'd250; dl_size = 25'd1000;
    tick(16);
    chk("osd_enable", enable, 0);
    chk("osd_busy", busy, 1);
    chk("osd_progress", progress, 32);
    osd_visible = 1'b0;
    tick(1);
    chk("osd_off_enable", enable, 1);
    dl_addr = 25'd5; dl_size = 25'd0;
    tick(4);
    dl_active = 1'b0;
    tick(1);
    chk("zero_drop_progress", progress, 127);

    // Reset during HOLD and during DIVIDE
    go_idle();
    dl_addr = 25'd500; dl_size = 25'd1000; dl_active = 1'b1;
    tick(12);
    dl_active = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    chk("rst_hold_enable", enable, 0);
    chk("rst_hold_progress", progress, 0);
    chk("rst_hold_busy", busy, 0);
    reset = 1'b0;
    dl_active = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    chk("rst_div_enable", enable, 0);
    chk("rst_div_progress", progress, 0);
    chk("rst_div_busy", busy, 0);
    reset = 1'b0;
    tick(16);
    chk("rst_restart_progress", progress, 64);
    chk("rst_restart_enable", enable, 1);

    // Randomized operands against the arithmetic reference
    for (int ph = 0; ph < 2; ph++) begin
      go_idle();
      for (int i = 0; i < 20; i++) begin
        case ($urandom_range(0, 5))
          0: begin rd = '0; rn = AW'($urandom()); end
          1: begin rd = AW'($urandom_range(1, 300)); rn = AW'($urandom_range(0, 310)); end
          5: begin rd = AW'($urandom_range(1, 1000)); rn = AW'($urandom()); end
          default: begin
            rd = AW'($urandom());
            if (rd == '0) rd = 25'd1;
            rn = AW'(32'($urandom()) % 32'(rd));
          end
        endcase
        rosd = 1'($urandom_range(0, 1));
        osd_visible = rosd;
        if (ph == 0) begin
          dl_addr = rn; dl_size = rd; dl_active = 1'b1;
          tape_active = 1'($urandom_range(0, 1));
          tape_pos = AW'($urandom()); tape_size = AW'($urandom());
        end else begin
          tape_pos = rn; tape_size = rd; tape_active = 1'b1;
          dl_addr = AW'($urandom()); dl_size = AW'($urandom());
        end
        tick(16);
        chk($sformatf("rand%0d_%0d_progress", ph, i), progress, ref_prog(rn, rd));
        chk($sformatf("rand%0d_%0d_enable", ph, i), enable, !rosd);
        chk($sformatf("rand%0d_%0d_src", ph, i), src, ph);
      end
    end
    go_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
